// File: rtl/muxn_skid.sv
// muxn_skid: N-way data selector feeding a two-entry skid buffer.
// A beat carries the selected channel (or zero for an out-of-range select).
// MAIN drives the output; SKID absorbs the one beat that arrives while MAIN
// is stalled, so in_ready can be a plain register with no path from out_ready.
module muxn_skid #(
    parameter int WIDTH  = 64,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err,
    output logic [7:0]              err_cnt,
    input  logic                    err_clr
);

    // One extra bit so NUM_IN = 2**SEL_W still compares correctly.
    localparam logic [SEL_W:0] NUM_IN_W = (SEL_W+1)'(NUM_IN);

    logic [WIDTH-1:0] sel_val;
    logic             sel_ok;
    logic [WIDTH-1:0] main_data;
    logic             main_valid;
    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;
    logic             in_ready_q;
    logic             sel_err_q;
    logic [7:0]       err_cnt_q;

    logic accept;
    logic pop;
    logic load_main;
    logic load_skid;
    logic move_skid;
    logic bad_acc;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign sel_ok = ({1'b0, sel} < NUM_IN_W);

    // Channel selection; out-of-range selects yield an all-zero beat.
    always_comb begin
        sel_val = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel_ok && ({1'b0, sel} == (SEL_W+1)'(k)))
                sel_val = in_data[k*WIDTH +: WIDTH];
        end
    end

    assign accept    = in_valid && in_ready_q;
    assign pop       = main_valid && out_ready;
    // An accept implies SKID is empty, so the new beat goes to MAIN whenever
    // MAIN is free or draining this cycle, otherwise it parks in SKID.
    assign load_main = accept && (!main_valid || pop);
    assign load_skid = accept && main_valid && !pop;
    // SKID full means no accept this cycle; a pop promotes SKID into MAIN.
    assign move_skid = pop && skid_valid;
    assign bad_acc   = accept && !sel_ok;

    // Occupancy control: entry valid bits and the registered ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            if (load_main || move_skid)
                main_valid <= 1'b1;
            else if (pop)
                main_valid <= 1'b0;

            if (load_skid) begin
                skid_valid <= 1'b1;
                in_ready_q <= 1'b0;
            end else if (move_skid) begin
                skid_valid <= 1'b0;
                in_ready_q <= 1'b1;
            end
        end
    end

    // MAIN payload; cleared on reset because it is visible on out_data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            main_data <= '0;
        else if (load_main)
            main_data <= sel_val;
        else if (move_skid)
            main_data <= skid_data;
    end

    // SKID payload; only meaningful while skid_valid, so no reset needed.
    always_ff @(posedge clk) begin
        if (load_skid)
            skid_data <= sel_val;
    end

    // Sticky select error and saturating count; a new error wins over a clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_err_q <= 1'b0;
            err_cnt_q <= 8'd0;
        end else if (bad_acc) begin
            sel_err_q <= 1'b1;
            err_cnt_q <= err_clr ? 8'd1 : sat_inc(err_cnt_q);
        end else if (err_clr) begin
            sel_err_q <= 1'b0;
            err_cnt_q <= 8'd0;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign sel_err   = sel_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_muxn_skid.sv
// Bench for muxn_skid: directed scenarios on a 3x64 instance, randomized
// scoreboard run on a 5x32 instance.
module tb_muxn_skid;

    logic clk = 1'b0;
    logic reset;

    // Instance A: WIDTH=64, NUM_IN=3
    logic [191:0] in_data_a;
    logic [1:0]   sel_a;
    logic         in_valid_a, in_ready_a, out_valid_a, out_ready_a;
    logic [63:0]  out_data_a;
    logic         sel_err_a, err_clr_a;
    logic [7:0]   err_cnt_a;

    // Instance B: WIDTH=32, NUM_IN=5
    logic [159:0] in_data_b;
    logic [2:0]   sel_b;
    logic         in_valid_b, in_ready_b, out_valid_b, out_ready_b;
    logic [31:0]  out_data_b;
    logic         sel_err_b, err_clr_b;
    logic [7:0]   err_cnt_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    muxn_skid #(.WIDTH(64), .NUM_IN(3), .SEL_W(2)) dut_a (
        .clk(clk), .reset(reset), .in_data(in_data_a), .sel(sel_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .out_data(out_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .sel_err(sel_err_a),
        .err_cnt(err_cnt_a), .err_clr(err_clr_a)
    );

    muxn_skid #(.WIDTH(32), .NUM_IN(5), .SEL_W(3)) dut_b (
        .clk(clk), .reset(reset), .in_data(in_data_b), .sel(sel_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .out_data(out_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .sel_err(sel_err_b),
        .err_cnt(err_cnt_b), .err_clr(err_clr_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        checks++; if (out_valid_a !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid_a); end
        checks++; if (in_ready_a !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready_a); end
        checks++; if (out_data_a !== 64'd0) begin failures++; $display("FAIL reset_out_data: got %0h expected 0", out_data_a); end
        checks++; if (sel_err_a !== 1'b0 || err_cnt_a !== 8'd0) begin failures++; $display("FAIL reset_err: got %0b/%0d expected 0/0", sel_err_a, err_cnt_a); end
    endtask

    task automatic test_streaming;
        logic [63:0] exp_v [3];
        exp_v[0] = 64'hA; exp_v[1] = 64'hB; exp_v[2] = 64'hC;
        in_data_a   = {64'hC, 64'hB, 64'hA};
        out_ready_a = 1'b1;
        in_valid_a  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sel_a = 2'(i);
            tick();
            checks++;
            if (out_valid_a !== 1'b1 || out_data_a !== exp_v[i] || in_ready_a !== 1'b1) begin
                failures++;
                $display("FAIL stream_%0d: got v=%0b d=%0h r=%0b expected v=1 d=%0h r=1", i, out_valid_a, out_data_a, in_ready_a, exp_v[i]);
            end
        end
        in_valid_a = 1'b0;
        tick();
        checks++; if (out_valid_a !== 1'b0) begin failures++; $display("FAIL stream_drain: got %0b expected 0", out_valid_a); end
    endtask

    task automatic test_backpressure;
        out_ready_a = 1'b0;
        in_valid_a  = 1'b1;
        sel_a       = 2'd0;
        in_data_a   = {64'h0, 64'h0, 64'h11};
        tick();
        checks++; if (out_data_a !== 64'h11 || out_valid_a !== 1'b1 || in_ready_a !== 1'b1) begin failures++; $display("FAIL bp_first: got d=%0h v=%0b r=%0b expected d=11 v=1 r=1", out_data_a, out_valid_a, in_ready_a); end
        in_data_a = {64'h0, 64'h0, 64'h22};
        tick();
        checks++; if (in_ready_a !== 1'b0 || out_data_a !== 64'h11) begin failures++; $display("FAIL bp_full: got r=%0b d=%0h expected r=0 d=11", in_ready_a, out_data_a); end
        // Offer a different beat while not ready; it must be ignored.
        in_data_a = {64'h0, 64'h0, 64'h33};
        tick();
        checks++; if (in_ready_a !== 1'b0 || out_data_a !== 64'h11 || out_valid_a !== 1'b1) begin failures++; $display("FAIL bp_hold: got r=%0b d=%0h v=%0b expected r=0 d=11 v=1", in_ready_a, out_data_a, out_valid_a); end
        in_valid_a  = 1'b0;
        out_ready_a = 1'b1;
        tick();
        checks++; if (out_data_a !== 64'h22 || out_valid_a !== 1'b1 || in_ready_a !== 1'b1) begin failures++; $display("FAIL bp_pop1: got d=%0h v=%0b r=%0b expected d=22 v=1 r=1", out_data_a, out_valid_a, in_ready_a); end
        tick();
        checks++; if (out_valid_a !== 1'b0) begin failures++; $display("FAIL bp_pop2: got v=%0b expected 0", out_valid_a); end
    endtask

    task automatic test_bad_select;
        in_data_a   = {64'h3333, 64'h2222, 64'h1111};
        out_ready_a = 1'b1;
        in_valid_a  = 1'b1;
        sel_a       = 2'd3;
        tick();
        checks++; if (out_valid_a !== 1'b1 || out_data_a !== 64'd0) begin failures++; $display("FAIL bad_zero: got v=%0b d=%0h expected v=1 d=0", out_valid_a, out_data_a); end
        checks++; if (sel_err_a !== 1'b1 || err_cnt_a !== 8'd1) begin failures++; $display("FAIL bad_first: got %0b/%0d expected 1/1", sel_err_a, err_cnt_a); end
        for (int i = 1; i < 300; i++) tick();
        checks++; if (err_cnt_a !== 8'd255 || sel_err_a !== 1'b1) begin failures++; $display("FAIL bad_sat: got %0b/%0d expected 1/255", sel_err_a, err_cnt_a); end
        in_valid_a = 1'b0;
        err_clr_a  = 1'b1;
        tick();
        err_clr_a  = 1'b0;
        checks++; if (sel_err_a !== 1'b0 || err_cnt_a !== 8'd0) begin failures++; $display("FAIL bad_clear: got %0b/%0d expected 0/0", sel_err_a, err_cnt_a); end
        tick();
    endtask

    task automatic test_clear_collision;
        out_ready_a = 1'b1;
        in_valid_a  = 1'b1;
        sel_a       = 2'd3;
        tick();
        tick();
        checks++; if (err_cnt_a !== 8'd2) begin failures++; $display("FAIL coll_pre: got %0d expected 2", err_cnt_a); end
        err_clr_a = 1'b1;
        tick();
        err_clr_a  = 1'b0;
        in_valid_a = 1'b0;
        checks++; if (sel_err_a !== 1'b1 || err_cnt_a !== 8'd1) begin failures++; $display("FAIL coll: got %0b/%0d expected 1/1", sel_err_a, err_cnt_a); end
        err_clr_a = 1'b1;
        tick();
        err_clr_a = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        out_ready_a = 1'b0;
        in_valid_a  = 1'b1;
        sel_a       = 2'd1;
        in_data_a   = {64'h0, 64'h5, 64'h0};
        tick();
        in_data_a   = {64'h0, 64'h6, 64'h0};
        tick();
        in_valid_a  = 1'b0;
        checks++; if (in_ready_a !== 1'b0 || out_valid_a !== 1'b1) begin failures++; $display("FAIL mid_full: got r=%0b v=%0b expected r=0 v=1", in_ready_a, out_valid_a); end
        #2 reset = 1'b1;
        #1;
        checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1 || out_data_a !== 64'd0) begin failures++; $display("FAIL mid_async: got v=%0b r=%0b d=%0h expected v=0 r=1 d=0", out_valid_a, in_ready_a, out_data_a); end
        #1 reset = 1'b0;
        out_ready_a = 1'b1;
        in_valid_a  = 1'b1;
        in_data_a   = {64'h0, 64'h0, 64'h77};
        sel_a       = 2'd0;
        tick();
        in_valid_a  = 1'b0;
        checks++; if (out_valid_a !== 1'b1 || out_data_a !== 64'h77) begin failures++; $display("FAIL mid_first: got v=%0b d=%0h expected v=1 d=77", out_valid_a, out_data_a); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid_a !== 1'b0) begin failures++; $display("FAIL mid_stale_%0d: got v=%0b d=%0h expected v=0", i, out_valid_a, out_data_a); end
        end
    endtask

    task automatic test_random;
        logic [31:0] q[$];
        logic [31:0] ch [5];
        logic [31:0] expv;
        logic        acc, pp;
        int          ecnt;
        logic        eflag;
        ecnt  = 0;
        eflag = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            checks++;
            if (out_valid_b !== (q.size() > 0) || in_ready_b !== (q.size() < 2)) begin
                failures++;
                $display("FAIL rand_ctrl@%0d: got v=%0b r=%0b expected occupancy %0d", cyc, out_valid_b, in_ready_b, q.size());
            end
            if (q.size() > 0) begin
                checks++;
                if (out_data_b !== q[0]) begin failures++; $display("FAIL rand_data@%0d: got %0h expected %0h", cyc, out_data_b, q[0]); end
            end
            checks++;
            if (sel_err_b !== eflag || err_cnt_b !== 8'(ecnt)) begin failures++; $display("FAIL rand_err@%0d: got %0b/%0d expected %0b/%0d", cyc, sel_err_b, err_cnt_b, eflag, ecnt); end

            in_valid_b  = ($urandom_range(0, 3) != 0);
            out_ready_b = ($urandom_range(0, 2) != 0);
            sel_b       = 3'($urandom_range(0, 7));
            for (int k = 0; k < 5; k++) begin
                ch[k] = $urandom;
                in_data_b[k*32 +: 32] = ch[k];
            end
            expv = (sel_b < 3'd5) ? ch[sel_b] : 32'd0;
            acc  = in_valid_b && (q.size() < 2);
            pp   = out_ready_b && (q.size() > 0);
            if (pp) void'(q.pop_front());
            if (acc) begin
                q.push_back(expv);
                if (sel_b >= 3'd5) begin
                    eflag = 1'b1;
                    if (ecnt < 255) ecnt++;
                end
            end
            tick();
        end
        in_valid_b = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        in_data_a   = '0; sel_a = '0; in_valid_a = 1'b0; out_ready_a = 1'b0; err_clr_a = 1'b0;
        in_data_b   = '0; sel_b = '0; in_valid_b = 1'b0; out_ready_b = 1'b0; err_clr_b = 1'b0;
        #2;
        test_reset();
        @(negedge clk);
        reset = 1'b0;
        test_streaming();
        test_backpressure();
        test_bad_select();
        test_clear_collision();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
